// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit beside the EX-stage ALU.
// Shift-add multiply and restoring divide share one hi/lo datapath.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             flush,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_n;

  logic [2:0]       op;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;

  logic             is_m;
  logic             accept;
  logic             is_div;
  logic             sgn_a;
  logic             sgn_b;
  logic             sa;
  logic             sb;
  logic             b_zero;
  logic             ovf;
  logic             special;
  logic             last;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] spec_res;

  assign is_m   = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign accept = start && !flush && is_m && (state != CALC);
  assign is_div = Funct3[2];
  assign last   = (cnt == LAST);

  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    unique case (Funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      3'b010: sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign sa    = sgn_a && SrcA[WIDTH-1];
  assign sb    = sgn_b && SrcB[WIDTH-1];
  assign abs_a = sa ? -SrcA : SrcA;
  assign abs_b = sb ? -SrcB : SrcB;

  assign b_zero  = (SrcB == '0);
  assign ovf     = is_div && !Funct3[0] && (SrcA == SMIN) && (&SrcB);
  assign special = is_div && (b_zero || ovf);

  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      b_zero:  spec_res = Funct3[1] ? SrcA : '1;
      ovf:     spec_res = Funct3[1] ? '0 : SMIN;
      default: ;
    endcase
  end

  // one iteration of each algorithm; op[2] picks which one advances
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;

  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  assign mul_hi  = mul_sum[WIDTH:1];
  assign mul_lo  = {mul_sum[0], lo[WIDTH-1:1]};

  assign div_sh   = {hi, lo[WIDTH-1]};
  assign div_ge   = (div_sh >= {1'b0, m});
  assign div_diff = div_sh[WIDTH-1:0] - m;
  assign div_hi   = div_ge ? div_diff : div_sh[WIDTH-1:0];
  assign div_lo   = {lo[WIDTH-2:0], div_ge};

  assign hi_n = op[2] ? div_hi : mul_hi;
  assign lo_n = op[2] ? div_lo : mul_lo;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fin_res;

  assign prod   = {hi_n, lo_n};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -lo_n : lo_n;
  assign rem    = neg_r ? -hi_n : hi_n;

  always_comb begin
    fin_res = quo;
    unique case (op)
      3'b000:                 fin_res = prod_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[2*WIDTH-1:WIDTH];
      3'b110, 3'b111:         fin_res = rem;
      default:                fin_res = quo;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          state_n = IDLE;
          if (accept) state_n = special ? DONE : CALC;
        end
        CALC: if (last) state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      cnt    <= '0;
      Result <= '0;
    end else if (accept) begin
      op    <= Funct3;
      neg_q <= sa ^ sb;
      neg_r <= sa;
      hi    <= '0;
      lo    <= is_div ? abs_a : abs_b;
      m     <= is_div ? abs_b : abs_a;
      cnt   <= '0;
      if (special) Result <= spec_res;
    end else if (state == CALC && !flush) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + CW'(1);
      if (last) Result <= fin_res;
    end
  end

  assign busy = (state == CALC) || accept;
  assign done = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit
// against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  ALUOp;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic        flush;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] Result;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .ALUOp(ALUOp),
    .Funct7(Funct7),
    .Funct3(Funct3),
    .flush(flush),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .busy(busy),
    .done(done),
    .Result(Result)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] model(input logic [2:0] f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint ub;
    longint p;
    logic [63:0] up;
    logic ovf;
    sa = $signed(a);
    sb = $signed(b);
    ub = {32'b0, b};
    ovf = (a == 32'h80000000) && (b == 32'hffffffff);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hffffffff;
        if (ovf) return 32'h80000000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hffffffff : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
    if (!f3[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !f3[0] && a == 32'h80000000 && b == 32'hffffffff;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hffffffff;
      3: return 32'h80000000;
      4: return 32'h7fffffff;
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one M-ext op in the current cycle (C0) and follows it until done.
  task automatic run_op(input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        output int dcyc,
                        output int nbusy,
                        output logic bdone,
                        output logic [31:0] res,
                        output logic moved);
    logic [31:0] r0;
    start = 1'b1;
    ALUOp = 2'b10;
    Funct7 = 7'b0000001;
    Funct3 = f3;
    SrcA = a;
    SrcB = b;
    #1;
    r0 = Result;
    nbusy = busy ? 1 : 0;
    dcyc = -1;
    moved = 1'b0;
    bdone = 1'b1;
    res = 32'hx;
    for (int c = 1; c <= 40 && dcyc < 0; c++) begin
      tick();
      start = 1'b0;
      SrcA = $urandom;
      SrcB = $urandom;
      Funct3 = 3'($urandom);
      #1;
      if (done) begin
        dcyc = c;
        bdone = busy;
        res = Result;
      end else begin
        if (busy) nbusy++;
        if (Result !== r0) moved = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (Result !== 32'h0) begin
      bad++;
      $display("FAIL reset_result: got %h want 0", Result);
    end
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  tf[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6,
                            3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] ta[12] = '{32'd7, 32'h80000000, 32'hffffffff,
                            32'hffffffff, 32'hfffffff9, 32'hfffffff9,
                            32'hfffffff9, 32'hfffffff9, 32'd5, 32'd5,
                            32'h80000000, 32'h80000000};
    logic [31:0] tb[12] = '{32'hfffffffd, 32'h80000000, 32'hffffffff,
                            32'hffffffff, 32'd2, 32'd2, 32'd2, 32'd2,
                            32'd0, 32'd0, 32'hffffffff, 32'hffffffff};
    logic [31:0] te[12] = '{32'hffffffeb, 32'h40000000, 32'hfffffffe,
                            32'hffffffff, 32'hfffffffd, 32'hffffffff,
                            32'h7ffffffc, 32'h1, 32'hffffffff, 32'd5,
                            32'h80000000, 32'h0};
    int tl[12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    int dcyc;
    int nbusy;
    logic bdone;
    logic [31:0] res;
    logic moved;
    for (int i = 0; i < 12; i++) begin
      tick();
      run_op(tf[i], ta[i], tb[i], dcyc, nbusy, bdone, res, moved);
      total++;
      if (res !== te[i]) begin
        bad++;
        $display("FAIL dir%0d_result: got %h want %h", i, res, te[i]);
      end
      total++;
      if (dcyc !== tl[i]) begin
        bad++;
        $display("FAIL dir%0d_latency: got %0d want %0d", i, dcyc, tl[i]);
      end
      total++;
      if (nbusy !== tl[i]) begin
        bad++;
        $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, nbusy, tl[i]);
      end
      total++;
      if (bdone !== 1'b0) begin
        bad++;
        $display("FAIL dir%0d_busy_in_done: got %b want 0", i, bdone);
      end
      total++;
      if (moved !== 1'b0) begin
        bad++;
        $display("FAIL dir%0d_result_early: got changed want stable", i);
      end
      tick();
      total++;
      if (done !== 1'b0) begin
        bad++;
        $display("FAIL dir%0d_done_pulse: got %b want 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int lat;
    int dcyc;
    int nbusy;
    logic bdone;
    logic [31:0] res;
    logic moved;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a = pick();
      b = pick();
      exp = model(f3, a, b);
      lat = is_special(f3, a, b) ? 1 : 33;
      tick();
      run_op(f3, a, b, dcyc, nbusy, bdone, res, moved);
      total++;
      if (res !== exp || dcyc !== lat || moved !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d f3=%0d a=%h b=%h: got %h at C%0d want %h at C%0d",
                 i, f3, a, b, res, dcyc, exp, lat);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] r0;
    int ndone;
    int nlate;
    logic b10;
    logic b11;
    int dcyc;
    int nbusy;
    logic bdone;
    logic [31:0] res;
    logic moved;
    tick();
    r0 = Result;
    start = 1'b1;
    ALUOp = 2'b10;
    Funct7 = 7'b0000001;
    Funct3 = 3'b100;
    SrcA = 32'd1000;
    SrcB = 32'd7;
    #1;
    ndone = 0;
    nlate = 0;
    b10 = 1'b0;
    b11 = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      tick();
      start = (c == 10);
      flush = (c == 10);
      #1;
      if (c == 10) b10 = busy;
      if (c == 11) b11 = busy;
      if (c > 11 && busy) nlate++;
      if (done) ndone++;
    end
    total++;
    if (b10 !== 1'b1) begin
      bad++;
      $display("FAIL flush_busy_c10: got %b want 1", b10);
    end
    total++;
    if (b11 !== 1'b0 || nlate !== 0) begin
      bad++;
      $display("FAIL flush_busy_after: got c11=%b late=%0d want 0 0", b11, nlate);
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL flush_no_done: got %0d want 0", ndone);
    end
    total++;
    if (Result !== r0) begin
      bad++;
      $display("FAIL flush_result_held: got %h want %h", Result, r0);
    end
    tick();
    run_op(3'b000, 32'd3, 32'd4, dcyc, nbusy, bdone, res, moved);
    total++;
    if (res !== 32'd12 || dcyc !== 33 || nbusy !== 33) begin
      bad++;
      $display("FAIL flush_next_mul: got %h C%0d busy=%0d want 0000000c C33 busy=33",
               res, dcyc, nbusy);
    end
  endtask

  task automatic test_decode();
    logic [1:0] aop[2] = '{2'b10, 2'b00};
    logic [6:0] f7[2] = '{7'b0000000, 7'b0000001};
    int nb;
    int nd;
    for (int v = 0; v < 2; v++) begin
      tick();
      start = 1'b1;
      ALUOp = aop[v];
      Funct7 = f7[v];
      Funct3 = 3'b000;
      SrcA = 32'd3;
      SrcB = 32'd5;
      #1;
      nb = busy ? 1 : 0;
      nd = 0;
      for (int c = 1; c <= 40; c++) begin
        tick();
        start = 1'b0;
        #1;
        if (busy) nb++;
        if (done) nd++;
      end
      total++;
      if (nb !== 0) begin
        bad++;
        $display("FAIL decode%0d_busy: got %0d busy cycles want 0", v, nb);
      end
      total++;
      if (nd !== 0) begin
        bad++;
        $display("FAIL decode%0d_done: got %0d done cycles want 0", v, nd);
      end
    end
  endtask

  task automatic test_reset_mid();
    int nb;
    tick();
    start = 1'b1;
    ALUOp = 2'b10;
    Funct7 = 7'b0000001;
    Funct3 = 3'b000;
    SrcA = 32'd9;
    SrcB = 32'd9;
    #1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (Result !== 32'h0 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got res=%h done=%b busy=%b want 0 0 0",
               Result, done, busy);
    end
    nb = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (busy || done) nb++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 36; c++) begin
      tick();
      if (busy || done) nb++;
    end
    total++;
    if (nb !== 0) begin
      bad++;
      $display("FAIL reset_mid_discard: got %0d active cycles want 0", nb);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f3[3] = '{3'b000, 3'b101, 3'b110};
    logic [31:0] a[3];
    logic [31:0] b[3];
    logic [31:0] exp;
    int lat;
    int dcyc;
    int nbusy;
    logic bdone;
    logic [31:0] res;
    logic moved;
    a[0] = $urandom;
    b[0] = $urandom;
    a[1] = $urandom;
    b[1] = $urandom_range(1, 1000);
    a[2] = pick();
    b[2] = 32'h0;
    tick();
    for (int i = 0; i < 3; i++) begin
      exp = model(f3[i], a[i], b[i]);
      lat = is_special(f3[i], a[i], b[i]) ? 1 : 33;
      run_op(f3[i], a[i], b[i], dcyc, nbusy, bdone, res, moved);
      total++;
      if (res !== exp || dcyc !== lat || nbusy !== lat || moved !== 1'b0) begin
        bad++;
        $display("FAIL b2b%0d: got %h C%0d busy=%0d want %h C%0d busy=%0d",
                 i, res, dcyc, nbusy, exp, lat, lat);
      end
    end
    tick();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    ALUOp = 2'b00;
    Funct7 = 7'b0;
    Funct3 = 3'b0;
    SrcA = 32'h0;
    SrcB = 32'h0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_decode();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit for the RV32M extension, sitting beside the ALU in the EX stage. It decodes ALUOp/Funct7/Funct3 the same way the ALU controller does, recognises M-extension encodings, and runs a multi-cycle shift-add multiply or restoring divide. While it runs, it raises a combinational stall request so the pipeline holds EX. It returns a WIDTH-bit result with a one-cycle done pulse and supports abort on pipeline flush.

## Interface
- WIDTH, 32, operand/result width; legal values ≥ 2; iteration counter is $clog2(WIDTH+1) bits
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  EX-stage request valid
- ALUOp  input  2  controller ALU opcode; M-ext only when 2'b10
- Funct7  input  7  instruction bits 31:25; M-ext only when 7'b0000001
- Funct3  input  3  selects operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- flush  input  1  synchronous abort
- SrcA  input  WIDTH  rs1 operand (multiplicand/dividend)
- SrcB  input  WIDTH  rs2 operand (multiplier/divisor)
- busy  output  1  stall request to pipeline
- done  output  1  result-valid pulse
- Result  output  WIDTH  result, held until next accept

## Operation
- States: IDLE, CALC, DONE.
- accept = start && !flush && ALUOp==2'b10 && Funct7==7'b0000001 && state∈{IDLE,DONE}.
  - Non-M encodings are ignored; no state change.
- On accept, latch op, operand magnitudes, and sign flags. Later SrcA/SrcB changes have no effect.
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Multiply:
  - WIDTH shift-add iterations into a 2·WIDTH product.
  - Negate the product if the sign flags differ.
  - MUL returns the low half; MULH* return the high half.
- Divide:
  - WIDTH restoring iterations on magnitudes.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases are resolved at accept, skip CALC, and go straight to DONE:
  - Divisor = 0: DIV/DIVU → all ones; REM/REMU → SrcA.
  - Signed overflow (SrcA = 2^(WIDTH-1), SrcB = all ones): DIV → 2^(WIDTH-1); REM → 0.
- Transitions:
  - IDLE → CALC (or DONE for special cases) on accept.
  - CALC → DONE after WIDTH iterations; Result is registered on this edge.
  - DONE → IDLE by default, or → CALC/DONE on accept (back-to-back).
- flush: any state → IDLE at the next edge. done is not raised and Result is unchanged. flush beats start in the same cycle.

## Timing
- Reset (async, rst_n=0): state IDLE, Result=0, done=0, busy=0, counter=0.
  - Reset mid-CALC discards the operation immediately.
- busy = (state==CALC) || accept. This is combinational so the pipeline stalls in the start cycle.
- done = (state==DONE) is registered and high for exactly one cycle. busy is 0 in DONE so EX advances.
- Normal latency, with the start cycle as C0:
  - CALC occupies C1..C(WIDTH).
  - done=1 in C(WIDTH+1).
  - busy is high C0..C(WIDTH).
- Special-case latency: done=1 in C1; busy is high in C0 only.
- Result changes only on the edge entering DONE and is stable otherwise.
- A start accepted in a DONE cycle begins a new operation; that cycle's done still reports the prior result.

## Test plan
All scenarios use WIDTH=32.
- MUL SrcA=7, SrcB=0xFFFFFFFD → Result=0xFFFFFFEB, busy high C0..C32, done only in C33.
- MULH 0x80000000×0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC; REMU → 1; each done in C33.
- Special cases, each done in C1:
  - DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Flush and decode:
  - flush in C10 of a DIV → busy=0 from C11, no done, Result unchanged.
  - Following MUL 3×4 → 12 with normal latency.
  - start with Funct7=0 → busy stays 0, no done.
- Reset and back-to-back:
  - rst_n low mid-CALC → Result/done/busy 0 immediately.
  - After release, a back-to-back start in the DONE cycle is accepted; the second done arrives 33 cycles later with the correct value.
